// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: sample format, per-layer map geometry and
// the signed max helper used by the pooling stages.
package cnn_pkg;

    localparam int DATA_W = 16;

    localparam int L1_MAP_W   = 88;
    localparam int L1_OUT_W   = 44;
    localparam int L1_NUM_OUT = 1936;

    typedef logic signed [DATA_W-1:0] sample_t;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/m_pool_1_8_line_buf.sv
// One pooled row of horizontal maxima from the even input row, held until the
// matching odd row arrives. Synchronous write, combinational read.
module pool_line_buf
    import cnn_pkg::*;
#(
    parameter int DEPTH = L1_OUT_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_idx_i,
    input  sample_t       wr_data_i,
    input  logic [AW-1:0] rd_idx_i,
    output sample_t       rd_data_o
);

    sample_t mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/m_pool_1_8.sv
// 2x2 stride-2 signed max-pool after the first conv layer (88x88 -> 44x44).
// Define POOL_RELU_EN to clamp negative pooled results to zero.
module m_pool_1_8
    import cnn_pkg::*;
#(
    parameter int MAP_W   = L1_MAP_W,
    parameter int OUT_W   = L1_OUT_W,
    parameter int NUM_OUT = L1_NUM_OUT
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] map_in,
    input  logic                     save_in,
    output logic signed [DATA_W-1:0] map_out,
    output logic                     save,
    output logic                     ready
);

    localparam int CW = $clog2(MAP_W);
    localparam int IW = $clog2(OUT_W);
    localparam int NW = $clog2(NUM_OUT + 1);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    sample_t       pair_q, pair_d;
    sample_t       map_out_q, map_out_d;
    logic          save_q, save_d;
    logic          ready_q, ready_d;
    logic [NW-1:0] out_cnt_q, out_cnt_d;

    logic          col_odd;
    logic          row_odd;
    logic          last_col;
    logic          last_row;
    logic          map_done;
    logic          lb_we;
    logic [IW-1:0] idx;
    sample_t       hmax;
    sample_t       vmax;
    sample_t       pooled;
    sample_t       lb_rd;

    always_comb begin
        col_odd  = col_q[0];
        row_odd  = row_q[0];
        last_col = (col_q == CW'(MAP_W - 1));
        last_row = (row_q == CW'(MAP_W - 1));
        map_done = (out_cnt_q == NW'(NUM_OUT));
        idx      = IW'(col_q >> 1);
        hmax     = smax(pair_q, map_in);
        vmax     = smax(lb_rd, hmax);
`ifdef POOL_RELU_EN
        pooled   = vmax[DATA_W-1] ? '0 : vmax;
`else
        pooled   = vmax;
`endif
        lb_we    = start && save_in && col_odd && !row_odd;
    end

    pool_line_buf #(
        .DEPTH (OUT_W),
        .AW    (IW)
    ) u_line_buf (
        .clk_i     (clk_in),
        .rst_i     (rst_n),
        .wr_en_i   (lb_we),
        .wr_idx_i  (idx),
        .wr_data_i (hmax),
        .rd_idx_i  (idx),
        .rd_data_o (lb_rd)
    );

    // Once the map is complete, samples still move the counters but no window emits.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        pair_d    = pair_q;
        map_out_d = map_out_q;
        save_d    = 1'b0;
        out_cnt_d = out_cnt_q;
        ready_d   = !map_done;

        if (!start) begin
            col_d     = '0;
            row_d     = '0;
            pair_d    = '0;
            map_out_d = '0;
        end else if (save_in) begin
            if (!col_odd) begin
                pair_d = map_in;
            end
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (col_odd && row_odd && !map_done) begin
                map_out_d = pooled;
                save_d    = 1'b1;
                out_cnt_d = out_cnt_q + NW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_n) begin
        if (rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            pair_q    <= '0;
            map_out_q <= '0;
            save_q    <= 1'b0;
            ready_q   <= 1'b1;
            out_cnt_q <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            pair_q    <= pair_d;
            map_out_q <= map_out_d;
            save_q    <= save_d;
            ready_q   <= ready_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign map_out = map_out_q;
    assign save    = save_q;
    assign ready   = ready_q;

endmodule
